lif_array_sched: RTL and testbench

Time-multiplexed scheduler for the leaky-integration neuron datapath, extended with threshold/fire and refractory handling. It shares one integrate/leak/compare unit across N_NEURONS membrane registers. Between time-step ticks it accumulates incoming currents per neuron. On each tick it sweeps all neurons, one per cycle, and publishes a spike vector. It sits between the input-current encoder and the spike output/readout logic of the chip.

---
 rtl/lif_pkg.sv | 26 ++
 rtl/lif_array_sched_if.sv | 30 +++
 rtl/lif_update_unit.sv | 40 ++++
 rtl/lif_array_sched.sv | 150 +++++++++++++++
 tb/tb_lif_array_sched.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed leaky-integrate-and-fire scheduler.
package lif_pkg;

    localparam int LIF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SWEEP   = 2'd1,
        ST_PUBLISH = 2'd2
    } fsm_e;

    // Index width, kept at least 1 so a degenerate neuron count still yields a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Unsigned add clamped to w bits; operands are zero-extended by the caller.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_array_sched_if.sv
// Current-input, tick, spike-output and debug-read bundle for lif_array_sched.
interface lif_array_sched_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = lif_pkg::LIF_WIDTH
);
    localparam int IDX_W = lif_pkg::idx_w(N_NEURONS);

    logic                 cur_valid;
    logic                 cur_ready;
    logic [IDX_W-1:0]     cur_idx;
    logic [WIDTH-1:0]     cur_data;
    logic                 tick;
    logic [WIDTH-1:0]     threshold;
    logic [N_NEURONS-1:0] spikes;
    logic                 spikes_valid;
    logic                 busy;
    logic                 overrun;
    logic [IDX_W-1:0]     rd_idx;
    logic [WIDTH-1:0]     rd_state;

    modport master (
        output cur_valid, cur_idx, cur_data, tick, threshold, rd_idx,
        input  cur_ready, spikes, spikes_valid, busy, overrun, rd_state
    );

    modport slave (
        input  cur_valid, cur_idx, cur_data, tick, threshold, rd_idx,
        output cur_ready, spikes, spikes_valid, busy, overrun, rd_state
    );
endinterface

// File: rtl/lif_update_unit.sv
// Single-neuron leak + integrate + saturate + threshold/refractory decision.
// Latency: combinational; no backpressure.
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int WIDTH      = LIF_WIDTH,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACT    = 2,
    parameter int RW         = 2
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] pending,
    input  logic [RW-1:0]    refr,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] next_state,
    output logic [RW-1:0]    next_refr,
    output logic             spike
);

    logic [WIDTH-1:0] leaked;
    logic [WIDTH-1:0] sum;

    always_comb begin
        leaked     = state >> LEAK_SHIFT;
        sum        = WIDTH'(sat_add(32'(pending), 32'(leaked), WIDTH));
        next_state = sum;
        next_refr  = refr;
        spike      = 1'b0;
        // A refractory neuron discards its integrated input for this step.
        if (refr != '0) begin
            next_state = '0;
            next_refr  = refr - RW'(1);
        end else if ((threshold != '0) && (sum >= threshold)) begin
            next_state = '0;
            next_refr  = RW'(REFRACT);
            spike      = 1'b1;
        end
    end

endmodule

// File: rtl/lif_array_sched.sv
// Shares one LIF update unit across N_NEURONS membranes; sweeps one neuron per cycle per tick.
// Latency: tick at t -> spikes_valid at t+N+1; cur_ready low while sweeping, one tick may queue.
module lif_array_sched
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = LIF_WIDTH,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACT    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    lif_array_sched_if.slave  bus
);

    localparam int IDX_W = idx_w(N_NEURONS);
    localparam int RW    = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    fsm_e                 fsm_q, fsm_d;
    logic [WIDTH-1:0]     state_q [N_NEURONS];
    logic [WIDTH-1:0]     state_d [N_NEURONS];
    logic [WIDTH-1:0]     pend_q  [N_NEURONS];
    logic [WIDTH-1:0]     pend_d  [N_NEURONS];
    logic [RW-1:0]        refr_q  [N_NEURONS];
    logic [RW-1:0]        refr_d  [N_NEURONS];
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_NEURONS-1:0] shadow_q, shadow_d;
    logic [N_NEURONS-1:0] spikes_q, spikes_d;
    logic                 tick_pend_q, tick_pend_d;
    logic                 overrun_q, overrun_d;

    logic [WIDTH-1:0]     u_next_state;
    logic [RW-1:0]        u_next_refr;
    logic                 u_spike;
    logic                 last_idx;
    logic                 start_req;

    assign last_idx  = (idx_q == IDX_W'(N_NEURONS - 1));
    assign start_req = bus.tick | tick_pend_q;

    lif_update_unit #(
        .WIDTH      (WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRACT    (REFRACT),
        .RW         (RW)
    ) u_update (
        .state      (state_q[idx_q]),
        .pending    (pend_q[idx_q]),
        .refr       (refr_q[idx_q]),
        .threshold  (bus.threshold),
        .next_state (u_next_state),
        .next_refr  (u_next_refr),
        .spike      (u_spike)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) fsm_q <= ST_IDLE;
        else          fsm_q <= fsm_d;
    end

    // A queued tick chains straight from PUBLISH into the next sweep.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE:    if (start_req) fsm_d = ST_SWEEP;
            ST_SWEEP:   if (last_idx)  fsm_d = ST_PUBLISH;
            ST_PUBLISH: fsm_d = start_req ? ST_SWEEP : ST_IDLE;
            default:    fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cur_ready    = (fsm_q == ST_IDLE);
        bus.busy         = (fsm_q != ST_IDLE);
        bus.spikes_valid = (fsm_q == ST_PUBLISH);
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        refr_d      = refr_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        spikes_d    = spikes_q;
        tick_pend_d = tick_pend_q;
        overrun_d   = overrun_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.cur_valid) begin
                    pend_d[bus.cur_idx] = WIDTH'(sat_add(32'(pend_q[bus.cur_idx]),
                                                         32'(bus.cur_data), WIDTH));
                end
                if (start_req) begin
                    tick_pend_d = 1'b0;
                    idx_d       = '0;
                    shadow_d    = '0;
                end
            end
            ST_SWEEP: begin
                state_d[idx_q]  = u_next_state;
                refr_d[idx_q]   = u_next_refr;
                pend_d[idx_q]   = '0;
                shadow_d[idx_q] = u_spike;
                idx_d           = idx_q + IDX_W'(1);
                // spikes is loaded on entry to PUBLISH so it is already current during the pulse.
                if (last_idx) spikes_d = shadow_d;
                if (bus.tick) begin
                    if (tick_pend_q) overrun_d   = 1'b1;
                    else             tick_pend_d = 1'b1;
                end
            end
            ST_PUBLISH: begin
                if (bus.tick && tick_pend_q) overrun_d = 1'b1;
                if (start_req) begin
                    tick_pend_d = 1'b0;
                    idx_d       = '0;
                    shadow_d    = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= '{default: '0};
            pend_q      <= '{default: '0};
            refr_q      <= '{default: '0};
            idx_q       <= '0;
            shadow_q    <= '0;
            spikes_q    <= '0;
            tick_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            refr_q      <= refr_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            spikes_q    <= spikes_d;
            tick_pend_q <= tick_pend_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.spikes   = spikes_q;
    assign bus.overrun  = overrun_q;
    assign bus.rd_state = state_q[bus.rd_idx];

endmodule

// File: tb/tb_lif_array_sched.sv
// Directed bench for lif_array_sched: scoreboard of expected spike pulses plus direct state checks.
module tb_lif_array_sched;
    import lif_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int LAT = N + 1;

    typedef struct {
        int         cyc;
        logic [N-1:0] spk;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    lif_array_sched_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    lif_array_sched #(
        .N_NEURONS (N),
        .WIDTH     (W),
        .LEAK_SHIFT(1),
        .REFRACT   (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every spikes_valid pulse must match the oldest expected pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.spikes_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_spikes_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("spikes_valid_cycle", cyc, e.cyc);
                check("spikes_vector", int'(bus.spikes), int'(e.spk));
            end
        end
    end

    task automatic send_cur(input int idx, input int data);
        bus.cur_valid = 1'b1;
        bus.cur_idx   = 2'(idx);
        bus.cur_data  = 8'(data);
        @(negedge clk);
        bus.cur_valid = 1'b0;
    endtask

    task automatic send_tick(input logic [N-1:0] spk);
        exp_t e;
        e.cyc = cyc + LAT;
        e.spk = spk;
        exp_q.push_back(e);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("idle_timeout", 1, 0);
    endtask

    task automatic check_state(input int idx, input int req, input string name);
        bus.rd_idx = 2'(idx);
        #1;
        check(name, int'(bus.rd_state), req);
    endtask

    initial begin
        exp_t e;
        int   t0;
        bus.cur_valid = 1'b0;
        bus.cur_idx   = '0;
        bus.cur_data  = '0;
        bus.tick      = 1'b0;
        bus.threshold = 8'd100;
        bus.rd_idx    = '0;

        // Reset with stray stimulus that must be ignored.
        repeat (2) @(negedge clk);
        bus.cur_valid = 1'b1;
        bus.cur_data  = 8'd77;
        bus.tick      = 1'b1;
        @(negedge clk);
        bus.cur_valid = 1'b0;
        bus.tick      = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_cur_ready", int'(bus.cur_ready), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_spikes", int'(bus.spikes), 0);
        check("reset_overrun", int'(bus.overrun), 0);
        check_state(0, 0, "reset_state0");

        // 1: integrate and fire on neuron 0.
        send_cur(0, 60); send_tick(4'b0000); wait_idle(); check_state(0, 60, "t1_state_60");
        send_cur(0, 60); send_tick(4'b0000); wait_idle(); check_state(0, 90, "t1_state_90");
        send_cur(0, 60); send_tick(4'b0001); wait_idle(); check_state(0, 0, "t1_fire_reset");
        check("t1_spikes_held", int'(bus.spikes), 1);

        // 2: refractory swallows two ticks of input.
        send_cur(0, 200); send_tick(4'b0000); wait_idle(); check_state(0, 0, "t2_refr_1");
        send_cur(0, 200); send_tick(4'b0000); wait_idle(); check_state(0, 0, "t2_refr_2");
        send_cur(0, 200); send_tick(4'b0001); wait_idle(); check_state(0, 0, "t2_fire");

        // 3: saturation then leak with firing disabled.
        bus.threshold = 8'd0;
        send_cur(2, 200); send_cur(2, 200);
        send_tick(4'b0000); wait_idle(); check_state(2, 255, "t3_saturate");
        send_tick(4'b0000); wait_idle(); check_state(2, 127, "t3_leak");

        // 4: current coincident with tick is included in that sweep.
        bus.threshold = 8'd100;
        e.cyc = cyc + LAT;
        e.spk = 4'b0000;
        exp_q.push_back(e);
        bus.cur_valid = 1'b1; bus.cur_idx = 2'd1; bus.cur_data = 8'd50; bus.tick = 1'b1;
        @(negedge clk);
        bus.cur_valid = 1'b0; bus.tick = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            check($sformatf("t4_cur_ready_low_%0d", k), int'(bus.cur_ready), 0);
            @(negedge clk);
        end
        check("t4_cur_ready_back", int'(bus.cur_ready), 1);
        check_state(1, 50, "t4_state1");
        check_state(2, 63, "t4_state2");

        // 5: one tick queued mid-sweep, a second one dropped.
        t0 = cyc;
        e.cyc = t0 + LAT;      e.spk = 4'b0000; exp_q.push_back(e);
        e.cyc = t0 + 2 * LAT;  e.spk = 4'b0000; exp_q.push_back(e);
        bus.tick = 1'b1; @(negedge clk);
        bus.tick = 1'b0; @(negedge clk);
        bus.tick = 1'b1; @(negedge clk);
        @(negedge clk);
        bus.tick = 1'b0;
        check("t5_overrun_set", int'(bus.overrun), 1);
        wait_idle();
        check("t5_idle_cycle", cyc, t0 + 2 * LAT + 1);
        check_state(1, 12, "t5_two_sweeps_state1");
        send_cur(3, 120); send_tick(4'b1000); wait_idle();
        check("t5_overrun_sticky", int'(bus.overrun), 1);
        check_state(3, 0, "t5_state3_fired");

        // 6: reset mid-sweep aborts without a pulse.
        send_cur(2, 99);
        bus.tick = 1'b1; @(negedge clk);
        bus.tick = 1'b0; @(negedge clk);
        reset_n = 1'b0; @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < N; i++) check_state(i, 0, $sformatf("t6_state%0d", i));
        check("t6_spikes", int'(bus.spikes), 0);
        check("t6_overrun", int'(bus.overrun), 0);
        check("t6_cur_ready", int'(bus.cur_ready), 1);
        check("t6_busy", int'(bus.busy), 0);
        check("pending_expected_pulses", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

endmodule
